// File: rtl/mac_pkg.sv
// Shared definitions for the multi-lane MAC pipeline.
//   - Default lane count and operand/accumulator widths.
//   - stage_flags_t: per-stage beat framing {valid, first, last}.
//   - sat_add(): signed add that clamps to a w-bit two's-complement range.
//     Widths up to 63 bits are supported, which keeps the sum exact in 65 bits.
package mac_pkg;

  localparam int unsigned MAC_LANES = 4;
  localparam int unsigned MAC_A_W   = 8;
  localparam int unsigned MAC_B_W   = 8;
  localparam int unsigned MAC_ACC_W = 32;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_flags_t;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               sat;
  } sat_res_t;

  // Both operands must already lie inside the w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                       input logic signed [63:0] addend,
                                       input int unsigned        w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t           r;
    s  = {acc[63], acc} + {addend[63], addend};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi) begin
      r.sum = hi[63:0];
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.sum = lo[63:0];
      r.sat = 1'b1;
    end else begin
      r.sum = s[63:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: S0 operand/bias capture, S1 signed multiply, S2 accumulate.
// Optional feature macro: MAC_SAT_EN (saturating accumulate + sticky o_sat).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_en            global pipeline enable; every register holds when low
//   i_s1_valid      beat in S1 is valid (accumulate on it)
//   i_s1_first      beat in S1 opens a group (seed from its bias)
//   i_a, i_b        signed operands presented with the input beat
//   i_bias          signed seed presented with the input beat
//   o_y             accumulator value (group result when out_valid)
//   o_sat           sticky per-group clamp flag (0 without MAC_SAT_EN)
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned A_W   = MAC_A_W,
  parameter int unsigned B_W   = MAC_B_W,
  parameter int unsigned ACC_W = MAC_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_s1_valid,
  input  logic                    i_s1_first,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  input  logic signed [ACC_W-1:0] i_bias,
  output logic signed [ACC_W-1:0] o_y,
  output logic                    o_sat
);

  logic signed [A_W-1:0]     r_a;
  logic signed [B_W-1:0]     r_b;
  logic signed [ACC_W-1:0]   r_bias0;
  logic signed [A_W+B_W-1:0] r_prod;
  logic signed [ACC_W-1:0]   r_bias1;
  logic signed [ACC_W-1:0]   r_acc;

  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_base;
  logic signed [ACC_W-1:0]   w_next;

  assign w_prod_ext = ACC_W'(r_prod);
  assign w_base     = i_s1_first ? r_bias1 : r_acc;

`ifdef MAC_SAT_EN
  sat_res_t w_res;
  logic     w_clamp;
  logic     r_sat;

  assign w_res   = sat_add(64'(w_base), 64'(w_prod_ext), ACC_W);
  assign w_next  = w_res.sum[ACC_W-1:0];
  assign w_clamp = w_res.sat;

  // A first beat restarts the sticky flag before folding in its own clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (i_en && i_s1_valid) begin
      r_sat <= (i_s1_first ? 1'b0 : r_sat) | w_clamp;
    end
  end

  assign o_sat = r_sat;
`else
  assign w_next = w_base + w_prod_ext;
  assign o_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_bias0 <= '0;
      r_prod  <= '0;
      r_bias1 <= '0;
      r_acc   <= '0;
    end else if (i_en) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_bias0 <= i_bias;
      r_prod  <= r_a * r_b;
      r_bias1 <= r_bias0;
      // Bubbles leave the accumulator untouched.
      if (i_s1_valid) begin
        r_acc <= w_next;
      end
    end
  end

  assign o_y = r_acc;

endmodule

// File: rtl/mac_vec_pipeline.sv
// Multi-lane signed MAC pipeline with valid/ready backpressure.
// Each lane accumulates a dot-product over a group of beats framed by
// in_first/in_last and emits one result per group, 2 cycles after the last beat.
// Optional feature macro: MAC_SAT_EN (saturating accumulation, out_sat flags).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_first/in_last      group framing of the beat
//   in_a, in_b            packed signed operands, lane 0 in LSBs
//   in_bias               packed signed group seeds, used on first beats
//   out_valid/out_ready   result handshake
//   out_y                 packed signed group results
//   out_sat               per-lane saturation flags
module mac_vec_pipeline
  import mac_pkg::*;
#(
  parameter int unsigned LANES = MAC_LANES,
  parameter int unsigned A_W   = MAC_A_W,
  parameter int unsigned B_W   = MAC_B_W,
  parameter int unsigned ACC_W = MAC_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  input  logic [LANES*ACC_W-1:0] in_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_y,
  output logic [LANES-1:0]       out_sat
);

  stage_flags_t r_s0;
  stage_flags_t r_s1;
  logic         r_out_valid;
  logic         w_en;

  // A held result freezes the whole pipeline, so nothing can overtake it.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0        <= '0;
      r_s1        <= '0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_s0        <= '{valid: in_valid, first: in_first, last: in_last};
      r_s1        <= r_s0;
      r_out_valid <= r_s1.valid && r_s1.last;
    end
  end

  assign out_valid = r_out_valid;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .A_W   (A_W),
      .B_W   (B_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (w_en),
      .i_s1_valid (r_s1.valid),
      .i_s1_first (r_s1.first),
      .i_a        (in_a[l*A_W +: A_W]),
      .i_b        (in_b[l*B_W +: B_W]),
      .i_bias     (in_bias[l*ACC_W +: ACC_W]),
      .o_y        (out_y[l*ACC_W +: ACC_W]),
      .o_sat      (out_sat[l])
    );
  end

endmodule
